// File: rtl/signed_mult_pipe_rs.sv
// Pipelined signed/unsigned multiplier with round-half-up rescaling, output saturation,
// valid/ready handshake with whole-pipe backpressure and a lockstep control sideband.
module signed_mult_pipe_rs #(
    parameter int WIDTH                 = 16,
    parameter int OUT_WIDTH             = 32,
    parameter int FRAC_BITS             = 0,
    parameter int STAGES                = 3,
    parameter int CONTROL_SIGNALS_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 x,
    input  logic [WIDTH-1:0]                 y,
    input  logic                             x_signed,
    input  logic                             y_signed,
    input  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_WIDTH-1:0]             result,
    output logic                             sat,
    output logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_out
);

    localparam int          PW = 2*WIDTH + 2;
    localparam int unsigned DL = STAGES - 1;

    localparam logic signed [PW-1:0] HALF    = (PW'(1) << FRAC_BITS) >> 1;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                             advance;
    logic signed [WIDTH:0]            x_ext;
    logic signed [WIDTH:0]            y_ext;
    logic signed [PW-1:0]             p_next;
    logic signed [PW-1:0]             p_rnd;
    logic signed [PW-1:0]             r_shift;
    logic [OUT_WIDTH-1:0]             result_next;
    logic                             sat_next;

    logic signed [PW-1:0]             p_pipe [1:DL];
    logic [STAGES:1]                  v_pipe;
    logic [CONTROL_SIGNALS_WIDTH-1:0] c_pipe [1:STAGES];

    always_comb begin
        advance  = out_ready | ~out_valid;
        in_ready = advance;
    end

    always_comb begin
        x_ext  = x_signed ? {x[WIDTH-1], x} : {1'b0, x};
        y_ext  = y_signed ? {y[WIDTH-1], y} : {1'b0, y};
        p_next = PW'(x_ext) * PW'(y_ext);
    end

    // HALF is zero when FRAC_BITS=0, so one expression covers both the rounded and exact paths.
    always_comb begin
        p_rnd       = p_pipe[DL] + HALF;
        r_shift     = p_rnd >>> FRAC_BITS;
        result_next = r_shift[OUT_WIDTH-1:0];
        sat_next    = 1'b0;
        if (r_shift > SAT_MAX) begin
            result_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat_next    = 1'b1;
        end else if (r_shift < SAT_MIN) begin
            result_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat_next    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            for (int unsigned i = 1; i <= DL; i++) begin
                p_pipe[i] <= '0;
            end
            for (int unsigned i = 1; i <= STAGES; i++) begin
                c_pipe[i] <= '0;
            end
            result <= '0;
            sat    <= 1'b0;
        end else if (advance) begin
            v_pipe[1]  <= in_valid;
            c_pipe[1]  <= ctrls_in;
            p_pipe[1]  <= p_next;
            for (int unsigned i = 2; i <= STAGES; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                c_pipe[i] <= c_pipe[i-1];
            end
            for (int unsigned i = 2; i <= DL; i++) begin
                p_pipe[i] <= p_pipe[i-1];
            end
            result <= result_next;
            sat    <= sat_next;
        end
    end

    always_comb begin
        out_valid = v_pipe[STAGES];
        ctrls_out = c_pipe[STAGES];
    end

endmodule
